// File: rtl/perip_bus_master_if.sv
// Request, response and bus-control signals of the peripheral bus initiator.
// The shared tristate data line is kept as a plain inout port on the
// initiator so that the bus resolution stays visible at the top level.
interface perip_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic        busy;

    // Initiator side: consumes requests and response acceptance, drives the rest
    modport master (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output mem_we,
        output mem_addr,
        output busy
    );

    // Core/peripheral side: the mirror image of the initiator
    modport slave (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  mem_we,
        input  mem_addr,
        input  busy
    );
endinterface

// File: rtl/perip_bus_master.sv
// Peripheral bus initiator. Requests from the core are buffered in a small
// FIFO and issued one at a time onto the shared mem_we/mem_addr/mem_data bus.
// Writes are posted and can stream at one per cycle; a read holds the bus
// pipeline until its response has been accepted, so ordering is strictly
// first-in first-out.
module perip_bus_master #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] IDLE_ADDR  = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    perip_bus_master_if.master  bus,
    inout  wire  [31:0]         mem_data
);

    localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } fifoEntry_t;

    fifoEntry_t     fifoMem_q [FIFO_DEPTH];
    logic [AW-1:0]  wrPtr_q, wrPtr_d;
    logic [AW-1:0]  rdPtr_q, rdPtr_d;
    logic [AW:0]    count_q, count_d;

    state_t         state_q;
    logic           memWe_q;
    logic [31:0]    memAddr_q;
    logic [31:0]    wdata_q;
    logic           rspValid_q;
    logic [31:0]    rspRdata_q;

    logic           fifoEmpty;
    logic           fifoFull;
    logic           push;
    logic           pop;
    fifoEntry_t     head;

    assign fifoEmpty = (count_q == '0);
    assign fifoFull  = (count_q == FULL_COUNT);
    assign push      = bus.req_valid && !fifoFull;
    assign head      = fifoMem_q[rdPtr_q];

    // Pop whenever the FSM is about to start a new bus transaction: from IDLE,
    // after a write closes, or on the response handshake of a read.
    always_comb begin
        pop = 1'b0;
        unique case (state_q)
            ST_IDLE:  pop = !fifoEmpty;
            ST_ISSUE: pop = memWe_q && !fifoEmpty;
            ST_RESP:  pop = bus.rsp_ready && !fifoEmpty;
            default:  pop = 1'b0;
        endcase
    end

    // Next pointers and occupancy; a simultaneous push and pop cancel out.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO bookkeeping registers, cleared so any queued work is dropped on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below the count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};
        end
    end

    // Bus sequencing FSM with all bus and response outputs held in registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            memWe_q    <= 1'b0;
            memAddr_q  <= IDLE_ADDR;
            wdata_q    <= '0;
            rspValid_q <= 1'b0;
            rspRdata_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        memWe_q   <= head.we;
                        memAddr_q <= head.addr;
                        wdata_q   <= head.wdata;
                        state_q   <= ST_ISSUE;
                    end else begin
                        memWe_q   <= 1'b0;
                        memAddr_q <= IDLE_ADDR;
                    end
                end

                ST_ISSUE: begin
                    if (memWe_q) begin
                        if (pop) begin
                            memWe_q   <= head.we;
                            memAddr_q <= head.addr;
                            wdata_q   <= head.wdata;
                            state_q   <= ST_ISSUE;
                        end else begin
                            memWe_q   <= 1'b0;
                            memAddr_q <= IDLE_ADDR;
                            state_q   <= ST_IDLE;
                        end
                    end else begin
                        rspRdata_q <= mem_data;
                        rspValid_q <= 1'b1;
                        memWe_q    <= 1'b0;
                        memAddr_q  <= IDLE_ADDR;
                        state_q    <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rspValid_q <= 1'b0;
                        if (pop) begin
                            memWe_q   <= head.we;
                            memAddr_q <= head.addr;
                            wdata_q   <= head.wdata;
                            state_q   <= ST_ISSUE;
                        end else begin
                            state_q   <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state_q   <= ST_IDLE;
                    memWe_q   <= 1'b0;
                    memAddr_q <= IDLE_ADDR;
                end
            endcase
        end
    end

    // The data line is only ever driven during a write; peripherals own it otherwise.
    assign mem_data = memWe_q ? wdata_q : 32'hzzzz_zzzz;

    assign bus.mem_we    = memWe_q;
    assign bus.mem_addr  = memAddr_q;
    assign bus.rsp_valid = rspValid_q;
    assign bus.rsp_rdata = rspRdata_q;
    assign bus.req_ready = !fifoFull;
    assign bus.busy      = !fifoEmpty || (state_q != ST_IDLE) || rspValid_q;

endmodule

// File: doc/perip_bus_master.md
# perip_bus_master

Bus initiator for the embedded SoC peripheral bus. It accepts read/write requests from the core through a valid/ready request port and buffers them in a small FIFO. It then issues them one at a time onto the shared `mem_we`/`mem_addr`/`mem_data` bus that the memory-mapped peripherals (LED, GPIO, timer) decode. Read data is returned through a valid/ready response port. Writes are posted; reads complete in order with one outstanding.

## Interface
- `FIFO_DEPTH`, 4: request FIFO entries; power of two, minimum 2.
- `IDLE_ADDR`, 32'h0000_0000: value driven on `mem_addr` when no transaction is active. No peripheral decodes this address.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: FIFO can accept; high when not full.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 32: target address.
- `req_wdata` in 32: write data; ignored for reads.
- `rsp_valid` out 1: read data available.
- `rsp_ready` in 1: consumer accepts read data.
- `rsp_rdata` out 32: captured read data.
- `mem_we` out 1: bus write strobe, registered.
- `mem_addr` out 32: bus address, registered.
- `mem_data` inout 32: shared data bus. Driven only while `mem_we`=1, high-Z otherwise.
- `busy` out 1: high when the FIFO is non-empty, the state is not IDLE, or `rsp_valid` is high.

## Operation
- **Request FIFO:** push on `req_valid && req_ready`. Entries are {we, addr, wdata}. Read/write pointers wrap modulo `FIFO_DEPTH`. The count register runs 0..`FIFO_DEPTH`. `req_ready` = (count != `FIFO_DEPTH`), decoded from the registered count. A push and a pop in the same cycle leave count unchanged. When full, `req_ready`=0 and `req_valid` is ignored.
- **FSM states:** IDLE, ISSUE, RESP.
  - IDLE: `mem_we`=0, `mem_addr`=`IDLE_ADDR`. If the FIFO is non-empty, pop the head, load `mem_we`/`mem_addr`/write-data register, and go to ISSUE.
  - ISSUE (exactly one cycle): the bus holds the transaction; `mem_data` is driven with the write data only if `mem_we`=1.
    - Write: the peripheral captures at the closing edge. If the FIFO is non-empty at that edge, pop the next entry and stay in ISSUE (back-to-back), else go to IDLE.
    - Read: sample `mem_data` into `rsp_rdata` at the closing edge, set `rsp_valid`, drive `mem_we`=0 and `mem_addr`=`IDLE_ADDR`, and go to RESP.
  - RESP: hold `rsp_valid` and `rsp_rdata` stable until `rsp_ready`. On the handshake edge, clear `rsp_valid`. At that same edge, pop the next entry into ISSUE if the FIFO is non-empty, else go to IDLE. No bus transaction is issued while in RESP.
- **Ordering:** strictly FIFO order. A write queued behind a read waits for that read's response handshake.
- **Bus contention:** `mem_data` is never driven when `mem_we`=0. Peripherals drive it only when `mem_we`=0 and the address matches, so the two never overlap.
- **Unmapped reads:** the bus floats. `rsp_rdata` captures whatever the bus resolves to; integration provides no default.
- **Reset (any time, including mid-ISSUE or RESP):**
  - FIFO emptied; state IDLE.
  - `mem_we`=0, `mem_addr`=`IDLE_ADDR`, `mem_data` released.
  - `rsp_valid`=0, `rsp_rdata`=0, `busy`=0, `req_ready`=1.
  - The in-flight transaction is discarded.

## Timing
- All outputs are registered except `req_ready` and `busy`, which are decoded from registers. There are no input-to-output combinational paths.
- **Write:** accepted at edge E0. The bus shows the write during cycle E1..E2; the peripheral captures at E2. Minimum push-to-capture latency is 2 edges.
- **Read:** accepted at E0, ISSUE during E1..E2, `rsp_valid`=1 from E2. Minimum latency is 2 cycles.
- **Write throughput:** 1 per cycle sustained while the FIFO is fed. Each ISSUE lasts exactly one cycle.
- **Read throughput:** at most 1 per 2 cycles. Each stall cycle with `rsp_ready`=0 adds 1 cycle.
- A push into an empty FIFO while in IDLE is popped at the next edge (no fall-through in the same cycle).

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles, release. Expect `mem_we`=0, `mem_addr`=0, `mem_data`=Z, `rsp_valid`=0, `req_ready`=1, `busy`=0.
- **Single write:** write 32'h0000_00A5 to 32'hFFFF_0040 against an LED-style responder model. Expect `mem_we`=1 for exactly one cycle, starting 1 cycle after acceptance, with `mem_data`=32'hA5. A subsequent read returns `rsp_rdata`=32'hA5 with `rsp_valid` 2 cycles after acceptance.
- **Back-to-back writes:** push 4 writes in 4 consecutive cycles to 0xFFFF0040 with data 1, 2, 3, 4. Expect 4 consecutive `mem_we`=1 cycles, and the model holds 4 at the end.
- **Full and backpressure:** hold `rsp_ready`=0, push 1 read, then 4 writes. Expect `req_ready`=0 after the FIFO fills, `rsp_valid` held with stable data, and no `mem_we` pulse. Raise `rsp_ready`; expect 4 write pulses following the handshake, in order.
- **Reset mid-operation:** assert `rst` during the ISSUE cycle of a write, with 2 entries still queued. Expect immediate `mem_we`=0, bus released, FIFO empty, and no further bus activity after release.
